fb_arbiter: RTL

- Single-port frame-buffer arbiter and sequencer in the 25 MHz pixel-clock domain.
- Shares one synchronous-read frame memory between three requesters:
  - display scanout: hard real-time, highest priority
  - image writer: valid/ready, middle priority
  - internal clear engine: fills the whole buffer with one colour, lowest priority
- Sits between the VGA timing/pixel path and the frame RAM; the pixel path issues addresses, the arbiter returns pixel data with fixed latency.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_clear_seq.sv | 75 +++++++
 rtl/fb_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer arbiter shared definitions: geometry, grant encoding and the
// clear-engine state type.
package fb_pkg;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 76800;   // 320x240 pixels
  localparam int READ_LAT = 1;

  // Last address the clear engine writes; the counter parks here.
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_t;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear engine: walks the whole frame buffer writing one latched colour.
//   clk_25    pixel clock
//   rst       synchronous active-high reset
//   clr_start start request (ignored unless idle)
//   clr_data  fill colour, latched on an accepted start
//   advance   arbiter strobe: the current clear write was granted this cycle
//   req       clear write pending (state RUN)
//   addr/data address and colour of the pending clear write
//   busy      clear in progress
//   done      one-cycle pulse after the final write is granted
//
// state    | meaning
// ---------+---------------------------------------------------------
// CLR_IDLE | waiting for clr_start
// CLR_RUN  | requesting writes; addr advances only when granted
// CLR_DONE | final write granted; done pulses for this one cycle
module fb_clear_seq
  import fb_pkg::*;
(
  input  logic              clk_25,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  input  logic              advance,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  clr_state_t state;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state <= CLR_IDLE;
      addr  <= '0;
      data  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CLR_IDLE: begin
          if (clr_start) begin
            state <= CLR_RUN;
            addr  <= '0;
            data  <= clr_data;
            busy  <= 1'b1;
          end
        end
        CLR_RUN: begin
          if (advance) begin
            // Counter holds at the last address rather than wrapping.
            if (addr == CLR_LAST) begin
              state <= CLR_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        CLR_DONE: state <= CLR_IDLE;
        default: begin
          state <= CLR_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req = (state == CLR_RUN);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display scanout > image writer > clear.
// The winner's command is registered onto mem_*; display reads return on
// disp_data with a fixed 1+READ_LAT cycle latency.
//   clk_25, rst                     clock, synchronous active-high reset
//   disp_req/disp_addr              display read request
//   disp_data/disp_valid            display read return
//   wr_valid/wr_addr/wr_data/wr_ready  writer valid/ready channel
//   clr_start/clr_data              clear request and fill colour
//   clr_busy/clr_done               clear status
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  frame RAM port
//   gnt                             grant of the command now on mem_*
module fb_arbiter
  import fb_pkg::*;
(
  input  logic              clk_25,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt
);

  logic              wr_fire;
  logic              clr_req;
  logic              clr_adv;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;
  logic [READ_LAT:0] rd_vld_sr;
  gnt_t              gnt_q;

  // The writer only ever loses to the display, so ready is just !disp_req.
  assign wr_ready = !disp_req && !rst;
  assign wr_fire  = wr_valid && wr_ready;
  assign clr_adv  = clr_req && !disp_req && !wr_fire;

  fb_clear_seq u_clear (
    .clk_25    (clk_25),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .advance   (clr_adv),
    .req       (clr_req),
    .addr      (clr_addr),
    .data      (clr_wdata),
    .busy      (clr_busy),
    .done      (clr_done)
  );

  always_ff @(posedge clk_25) begin
    if (rst) begin
      gnt_q     <= GNT_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld_sr <= '0;
    end else begin
      rd_vld_sr <= {rd_vld_sr[READ_LAT-1:0], disp_req};
      if (disp_req) begin
        gnt_q    <= GNT_DISP;
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (wr_fire) begin
        gnt_q     <= GNT_WR;
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (clr_req) begin
        gnt_q     <= GNT_CLR;
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= clr_addr;
        mem_wdata <= clr_wdata;
      end else begin
        // Address and data hold so an idle RAM port does not toggle.
        gnt_q  <= GNT_NONE;
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  assign disp_valid = rd_vld_sr[READ_LAT];
  assign disp_data  = disp_valid ? mem_rdata : '0;
  assign gnt        = gnt_q;

endmodule
